// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial front end.
package serializer_pkg;
  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

  localparam int SER_MAX_W = 32;

  function automatic int ser_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/bit_serializer_if.sv
// Load handshake plus serial output bundle between the serializer and its neighbours.
interface bit_serializer_if #(parameter int DATA_W = 8) ();
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              shift_en;
  logic              w;
  logic              w_valid;
  logic              busy;
  logic              done;

  modport master (output load_valid, load_data, shift_en,
                  input  load_ready, w, w_valid, busy, done);
  modport slave  (input  load_valid, load_data, shift_en,
                  output load_ready, w, w_valid, busy, done);
endinterface

// File: rtl/bit_serializer_even_parity.sv
// Even parity of a data word: 1 when the word holds an odd number of ones.
module even_parity #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    output logic              parity
);
    assign parity = ^data;
endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one word in over valid/ready, one bit per strobe out on w.
// Optional trailing even-parity bit when SERIALIZER_PARITY_EN is defined.
module bit_serializer
  import serializer_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input logic             clock,
    input logic             reset,
    bit_serializer_if.slave bus
);
`ifdef SERIALIZER_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int CW = ser_cnt_w(NBITS);

    if (DATA_W < 2 || DATA_W > SER_MAX_W) begin : g_bad_width
        $error("bit_serializer: DATA_W out of range");
    end

    ser_state_t        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              done_q, done_d;
    logic              head_bit, cur_bit, last_bit, consume, accept;

    // The shift register moves the next bit into the head position, so no variable index is needed.
    assign head_bit = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
    assign last_bit = (bit_cnt_q == CW'(NBITS - 1));
    assign consume  = (state_q == SER_SHIFT) & bus.shift_en;

`ifdef SERIALIZER_PARITY_EN
    logic par_q, par_d, load_par;

    even_parity #(.DATA_W(DATA_W)) u_parity (
        .data   (bus.load_data),
        .parity (load_par)
    );

    assign par_d   = accept ? load_par : par_q;
    assign cur_bit = (bit_cnt_q == CW'(DATA_W)) ? par_q : head_bit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) par_q <= 1'b0;
        else        par_q <= par_d;
    end
`else
    assign cur_bit = head_bit;
`endif

    assign bus.load_ready = reset & ((state_q == SER_IDLE) | (last_bit & consume));
    assign accept         = bus.load_valid & bus.load_ready;
    assign bus.w          = (state_q == SER_SHIFT) ? cur_bit : IDLE_BIT;
    assign bus.w_valid    = (state_q == SER_SHIFT);
    assign bus.busy       = (state_q == SER_SHIFT);
    assign bus.done       = done_q;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        if (consume) begin
            if (last_bit) begin
                state_d   = SER_IDLE;
                bit_cnt_d = '0;
                done_d    = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
                shreg_d   = MSB_FIRST ? {shreg_q[DATA_W-2:0], 1'b0}
                                      : {1'b0, shreg_q[DATA_W-1:1]};
            end
        end
        // A reload in the last-bit cycle overrides the return to idle.
        if (accept) begin
            state_d   = SER_SHIFT;
            shreg_d   = bus.load_data;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= SER_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
        end
    end
endmodule
